// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: shares one synchronous FIFO among NUM_REQ producers.
// The write side uses a round-robin arbiter with a combinational grant and a
// registered priority pointer. The read side is a two-state FSM that covers
// the FIFO's one-cycle read latency and feeds a valid/ready output.
module fifo_arb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,   // active-high synchronous reset
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic                          fifo_rd_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  input  logic                          fifo_empty,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    last_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {R_IDLE, R_WAIT} rd_state_t;

  logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]      last_grant_reg;
  logic [IDX_W-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    cand_hit;
  logic [DATA_WIDTH-1:0] s_slice  [NUM_REQ];
  logic                  grant_any;
  logic                  grant_ok;
  logic [IDX_W-1:0]      grant_idx;

  rd_state_t             state_reg, state_next;
  logic                  m_valid_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;

  // Candidate gi is the requester gi positions after the priority pointer.
  // Unpacking s_data here keeps the data mux a plain array lookup.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                            IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
      assign cand_hit[gi] = s_valid[cand_idx[gi]];
      assign s_slice[gi]  = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Pick the valid candidate nearest the pointer. The descending scan lets the
  // lowest offset win.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  assign grant_ok    = grant_any & en & ~fifo_full & ~reset_n;
  assign rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Drive the write port. Unselected slices are zeroed so they never leak
  // onto fifo_data_in.
  always_comb begin
    s_ready      = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    if (grant_ok) begin
      s_ready[grant_idx] = 1'b1;
      fifo_wr_en         = 1'b1;
      fifo_data_in       = s_slice[grant_idx];
    end
  end

  // Advance the priority pointer just past the winner. Hold it when there is
  // no grant.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rr_ptr_reg     <= '0;
      last_grant_reg <= '0;
    end else if (grant_ok) begin
      rr_ptr_reg     <= rr_ptr_next;
      last_grant_reg <= grant_idx;
    end
  end

  // Read FSM next state. A read starts only when the output slot is free or is
  // being emptied this cycle.
  always_comb begin
    state_next = state_reg;
    fifo_rd_en = 1'b0;
    case (state_reg)
      R_IDLE: begin
        if (!reset_n && en && !fifo_empty && (!m_valid_reg || m_ready)) begin
          fifo_rd_en = 1'b1;
          state_next = R_WAIT;
        end
      end
      R_WAIT: state_next = R_IDLE;
    endcase
  end

  // State register and output holding register. The word read in R_WAIT is
  // captured even if en has dropped.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_reg   <= R_IDLE;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == R_WAIT) begin
        m_data_reg  <= fifo_data_out;
        m_valid_reg <= 1'b1;
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign last_grant = last_grant_reg;
  assign fifo_cs    = fifo_wr_en | fifo_rd_en;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl: drives fifo_arb_ctrl against a queue-based FIFO.
// A behavioural model is checked every cycle, and directed literal checks
// cover reset, round-robin order, wrap, backpressure, read latency and stall.
module tb_fifo_arb_ctrl;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          en = 1'b0;
  logic [NR-1:0] s_valid = '0;
  logic [NR*DW-1:0] s_data = '0;
  logic [NR-1:0] s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          fifo_cs, fifo_wr_en, fifo_rd_en;
  logic [DW-1:0] fifo_data_in;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty, fifo_full;
  logic [1:0]    last_grant;

  // FIFO model state and test overrides
  logic [DW-1:0] fq[$];
  logic          fifo_empty_cap = 1'b1;
  logic          fifo_full_cap  = 1'b0;
  logic          force_full     = 1'b0;
  logic          force_nonempty = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  int            mdl_ptr = 0;
  int            mdl_last = 0;
  bit            mdl_vld = 0;
  bit            mdl_inflight = 0;
  logic [DW-1:0] mdl_data = '0;
  logic [DW-1:0] sb[$];
  int            exp_g;
  logic [NR-1:0] exp_ready;
  logic [DW-1:0] exp_din;
  bit            exp_rd;

  assign fifo_empty = fifo_empty_cap & ~force_nonempty;
  assign fifo_full  = fifo_full_cap | force_full;

  fifo_arb_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO with one-cycle registered read data, cleared by the same reset
  always @(posedge clk) begin
    if (reset_n) begin
      fq.delete();
      fifo_data_out  <= '0;
      fifo_empty_cap <= 1'b1;
      fifo_full_cap  <= 1'b0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_data_out <= fq.pop_front();
      if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_data_in);
      fifo_empty_cap <= (fq.size() == 0);
      fifo_full_cap  <= (fq.size() >= DEPTH);
    end
  end

  // Model: compute the required outputs for this cycle, compare, then advance
  always @(negedge clk) begin
    exp_g = -1;
    if (!reset_n && en && !fifo_full) begin
      for (int off = 0; off < NR; off++) begin
        if (exp_g < 0 && s_valid[(mdl_ptr + off) % NR]) exp_g = (mdl_ptr + off) % NR;
      end
    end
    exp_ready = '0;
    exp_din   = '0;
    if (exp_g >= 0) begin
      exp_ready[exp_g] = 1'b1;
      exp_din = s_data[exp_g*DW +: DW];
    end
    exp_rd = !reset_n && en && !fifo_empty && !mdl_inflight && (!mdl_vld || m_ready);

    chk("s_ready",      32'(s_ready),      32'(exp_ready));
    chk("fifo_wr_en",   32'(fifo_wr_en),   32'(exp_g >= 0));
    chk("fifo_data_in", 32'(fifo_data_in), 32'(exp_din));
    chk("fifo_rd_en",   32'(fifo_rd_en),   32'(exp_rd));
    chk("fifo_cs",      32'(fifo_cs),      32'(exp_rd || (exp_g >= 0)));
    chk("m_valid",      32'(m_valid),      32'(mdl_vld));
    chk("m_data",       32'(m_data),       32'(mdl_data));
    chk("last_grant",   32'(last_grant),   32'(mdl_last));

    if (reset_n) begin
      mdl_ptr = 0; mdl_last = 0; mdl_vld = 0; mdl_inflight = 0; mdl_data = '0;
      sb.delete();
    end else begin
      if (mdl_vld && m_ready) $display("OUT   word %02h at %0t", mdl_data, $time);
      if (exp_g >= 0) begin
        $display("WRITE req %0d word %02h at %0t", exp_g, exp_din, $time);
        sb.push_back(exp_din);
        mdl_last = exp_g;
        mdl_ptr  = (exp_g + 1) % NR;
      end
      if (mdl_inflight) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) mdl_data = sb.pop_front();
        mdl_vld = 1;
      end else if (mdl_vld && m_ready) begin
        mdl_vld = 0;
      end
      mdl_inflight = exp_rd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  // Stimulus with directed literal expectations, followed by random traffic
  initial begin
    // reset with every requester valid and FIFO claiming data
    reset_n = 1'b1; en = 1'b1; m_ready = 1'b1; s_valid = '1; force_nonempty = 1'b1;
    s_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_wr_en",   32'(fifo_wr_en), 32'd0);
      chk("rst_rd_en",   32'(fifo_rd_en), 32'd0);
      chk("rst_cs",      32'(fifo_cs), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_last",    32'(last_grant), 32'd0);
      tick();
    end
    reset_n = 1'b0; force_nonempty = 1'b0;

    // round-robin across all four requesters
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_s_ready", 32'(s_ready), 32'(4'b0001 << (k % 4)));
      chk("rr_data",    32'(fifo_data_in), 32'(8'h10 + (k % 4)));
      if (k > 0) chk("rr_last", 32'(last_grant), 32'((k - 1) % 4));
      tick();
    end
    // three more grants (0,1,2) leave the pointer at 3
    for (int k = 0; k < 3; k++) tick();

    // skip idle requesters and wrap from 3 to 0
    s_valid = 4'b0101;
    @(negedge clk); chk("skip_ready0", 32'(s_ready), 32'b0001); chk("skip_last0", 32'(last_grant), 32'd2); tick();
    @(negedge clk); chk("skip_ready1", 32'(s_ready), 32'b0100); chk("skip_last1", 32'(last_grant), 32'd0); tick();
    @(negedge clk); chk("skip_ready2", 32'(s_ready), 32'b0001); chk("skip_last2", 32'(last_grant), 32'd2); tick();
    s_valid = '0;
    @(negedge clk); chk("skip_last3", 32'(last_grant), 32'd0); tick();

    // full blocks everything, release grants in the same cycle
    s_valid = 4'b0010; force_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_ready", 32'(s_ready), 32'd0);
      chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
      tick();
    end
    force_full = 1'b0;
    @(negedge clk); chk("unfull_ready", 32'(s_ready), 32'b0010); tick();

    // drain everything
    s_valid = '0; m_ready = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    @(negedge clk);
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    chk("drain_m_valid", 32'(m_valid), 32'd0);
    tick();

    // read path latency: A5 then 5A
    s_valid = 4'b0001; s_data[7:0] = 8'hA5;
    @(negedge clk); chk("rd_wr_a5", 32'(fifo_wr_en), 32'd1); tick();
    s_data[7:0] = 8'h5A;
    @(negedge clk); chk("rd_t_rd_en", 32'(fifo_rd_en), 32'd1); tick();
    s_valid = '0;
    @(negedge clk); chk("rd_t1_rd_en", 32'(fifo_rd_en), 32'd0); tick();
    @(negedge clk);
    chk("rd_t2_valid", 32'(m_valid), 32'd1);
    chk("rd_t2_data",  32'(m_data), 32'hA5);
    chk("rd_t2_rd_en", 32'(fifo_rd_en), 32'd1);
    tick();
    @(negedge clk); chk("rd_t3_rd_en", 32'(fifo_rd_en), 32'd0); tick();
    @(negedge clk);
    chk("rd_t4_valid", 32'(m_valid), 32'd1);
    chk("rd_t4_data",  32'(m_data), 32'h5A);
    chk("rd_t4_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_t5_valid", 32'(m_valid), 32'd0);
    chk("rd_t5_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();

    // output stall: B0 held while m_ready is low, B1/B2 follow in order
    m_ready = 1'b0; s_valid = 4'b0001; s_data[7:0] = 8'hB0;
    @(negedge clk); chk("stall_wr_b0", 32'(s_ready), 32'b0001); tick();
    s_data[7:0] = 8'hB1;
    @(negedge clk); chk("stall_rd_en", 32'(fifo_rd_en), 32'd1); tick();
    s_data[7:0] = 8'hB2;
    @(negedge clk); tick();
    s_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data",  32'(m_data), 32'hB0);
      chk("stall_no_rd", 32'(fifo_rd_en), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk); chk("unstall_rd_en", 32'(fifo_rd_en), 32'd1); tick();
    for (int k = 0; k < 8; k++) tick();

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 2000; i++) begin
      s_valid    = NR'($urandom);
      s_data     = $urandom;
      en         = ($urandom_range(0, 9) != 0);
      m_ready    = ($urandom_range(0, 3) != 0);
      force_full = ($urandom_range(0, 11) == 0);
      reset_n    = (i == 1000 || i == 1001);
      tick();
    end

    s_valid = '0; en = 1'b1; m_ready = 1'b1; force_full = 1'b0; reset_n = 1'b0;
    for (int k = 0; k < 60; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_arb_ctrl.md
Name: fifo_arb_ctrl

Overview:
- Controller that shares one synchronous FIFO instance among NUM_REQ producers and drains it to a single consumer.
- Write side: round-robin arbitration of valid/ready producers onto the FIFO cs/wr_en/data_in port.
- Read side: a small FSM issues rd_en, absorbs the FIFO's one-cycle read latency and presents data on a valid/ready output.
- Sits directly between producer blocks and the `fifo` module, and drives all of its control inputs.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- NUM_REQ, 4, number of producer ports (>=2).
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived localparam).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  synchronous reset, ACTIVE-HIGH. The codebase port name is kept; 1 means reset.
- en  in  1  global enable; 0 blocks new grants and new reads.
- s_valid  in  NUM_REQ  per-producer request valid.
- s_data  in  NUM_REQ*DATA_WIDTH  producer data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_ready  out  NUM_REQ  one-hot accept; a transfer occurs when s_valid[i] and s_ready[i] are both 1.
- m_valid  out  1  output word valid.
- m_data  out  DATA_WIDTH  output word.
- m_ready  in  1  consumer accept.
- fifo_cs  out  1  FIFO chip select.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_data_in  out  DATA_WIDTH  word written to the FIFO.
- fifo_data_out  in  DATA_WIDTH  FIFO read data; valid the cycle after rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- last_grant  out  IDX_W  index of the most recently granted producer.

Behaviour:
- Reset (reset_n=1 at a clock edge):
  - rr_ptr=0, last_grant=0, m_valid=0, m_data=0, read FSM to R_IDLE.
  - While reset_n=1, s_ready, fifo_wr_en, fifo_rd_en and fifo_cs are forced to 0 combinationally.
- Write arbitration (combinational grant, registered pointer):
  - Candidate g = first i with s_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Grant only when en=1, fifo_full=0 and at least one s_valid is 1.
  - On grant: s_ready = one-hot(g); fifo_wr_en=1; fifo_data_in = s_data slice g.
  - With no grant: s_ready=0, fifo_wr_en=0, fifo_data_in=0.
  - Register update on a grant: rr_ptr <= (g+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0); last_grant <= g.
  - No grant leaves rr_ptr and last_grant unchanged.
  - Max one write per cycle. Zero-cycle latency from s_valid to s_ready.
  - fifo_full=1 blocks every requester; valid inputs are held by the producers.
- Read FSM, states R_IDLE and R_WAIT:
  - R_IDLE: if en=1, fifo_empty=0 and (m_valid=0 or m_ready=1), then fifo_rd_en=1 and next state is R_WAIT. Otherwise fifo_rd_en=0.
  - R_WAIT: fifo_rd_en=0; m_data <= fifo_data_out; m_valid <= 1; next state R_IDLE.
  - A pending m_valid that m_ready consumes in the same cycle is replaced. Data is never dropped or duplicated.
  - m_valid clears on m_valid & m_ready unless R_WAIT reloads it in that cycle.
  - m_data/m_valid are stable while m_valid=1 and m_ready=0.
  - Peak read throughput: 1 word per 2 cycles.
  - Deasserting en in R_WAIT still completes the in-flight capture.
- fifo_cs = fifo_wr_en | fifo_rd_en.
- Simultaneous write and read in the same cycle are allowed. The FIFO is responsible for simultaneous read/write semantics at full and empty.
- Reset while in R_WAIT discards the in-flight read word. The FIFO is reset on the same reset.
- No X propagation: unselected s_data slices never reach fifo_data_in.

Test Plan:
- Reset: hold reset_n=1 for 3 cycles with all s_valid=1 and fifo_empty=0 -> s_ready=0, fifo_wr_en=0, fifo_rd_en=0, fifo_cs=0, m_valid=0, last_grant=0.
- Round-robin fairness: s_valid=4'b1111 for 8 cycles, fifo_full=0 -> grants 0,1,2,3,0,1,2,3, each s_ready one-hot; fifo_data_in matches the granted slice (data = 8'h10+i).
- Skip and wrap: rr_ptr=3, s_valid=4'b0101 -> grant 0, then 2, then 0; last_grant tracks; no grant is issued to idle requesters.
- Full backpressure: fifo_full=1 for 5 cycles with s_valid=4'b0010 -> s_ready=0, fifo_wr_en=0; fifo_full drops -> requester 1 granted in that same cycle.
- Read path: FIFO preloaded with 8'hA5, 8'h5A; m_ready=1 -> rd_en at cycle t, m_valid=1 and m_data=8'hA5 at t+2, 8'h5A at t+4, then empty and rd_en stays 0.
- Output stall: m_ready=0 with m_valid=1 -> no further fifo_rd_en and m_data held; m_ready=1 -> next read issued that cycle, no word lost or duplicated (scoreboard order check).
